// File: rtl/hue_fader_pkg.sv
// Shared types and the channel-shape lookup for the multi-channel hue fader.
package fade_pkg;

  localparam int NUM_SECTORS = 6;

  typedef enum logic {
    MODE_HUE     = 1'b0,
    MODE_BREATHE = 1'b1
  } mode_e;

  typedef enum logic [1:0] {
    SH_LOW,
    SH_RISE,
    SH_HIGH,
    SH_FALL
  } shape_e;

  // HUE rotates each channel backwards round the wheel by channel*offset sectors.
  function automatic shape_e shape_of(input mode_e mode, input logic [2:0] sector,
                                      input int channel, input int offset);
    int     rel;
    shape_e sh;
    rel = 0;
    if (mode == MODE_BREATHE) begin
      sh = (sector == 3'd0) ? SH_RISE : SH_FALL;
    end else begin
      rel = (int'(sector) + NUM_SECTORS - ((channel * offset) % NUM_SECTORS)) % NUM_SECTORS;
      case (rel)
        0:       sh = SH_RISE;
        1, 2:    sh = SH_HIGH;
        3:       sh = SH_FALL;
        default: sh = SH_LOW;
      endcase
    end
    return sh;
  endfunction

endpackage

// File: rtl/hue_fader_if.sv
// Control and duty-value bundle between the fader and its PWM consumers.
// step_tick/wrap are single-cycle strobes with no backpressure; pwm_value and sector are always valid.
interface hue_fader_if #(
  parameter int NUM_CHANNELS = 3,
  parameter int W            = 11
);
  logic                      en;
  logic                      mode;
  logic [NUM_CHANNELS*W-1:0] pwm_value;
  logic [2:0]                sector;
  logic                      step_tick;
  logic                      wrap;

  modport master (
    output en, mode,
    input  pwm_value, sector, step_tick, wrap
  );

  modport slave (
    input  en, mode,
    output pwm_value, sector, step_tick, wrap
  );
endinterface

// File: rtl/hue_fader_tick_gen.sv
// Free-running step-interval counter; emits a combinational tick on its last count.
module fade_tick_gen #(
  parameter int STEP_INTERVAL = 2000000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tick
);
  localparam int             CW   = (STEP_INTERVAL > 1) ? $clog2(STEP_INTERVAL) : 1;
  localparam logic [CW-1:0]  LAST = CW'(STEP_INTERVAL - 1);

  logic [CW-1:0] r_cnt;

  // A clear on the same edge suppresses the tick so the position restarts cleanly.
  assign o_tick = i_en && !i_clr && (r_cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/hue_fader.sv
// Multi-channel colour-wheel / breathing fader: position tracker plus registered per-channel duty levels.
module hue_fader
  import fade_pkg::*;
#(
  parameter int PWM_INTERVAL     = 1200,
  parameter int STEPS_PER_SECTOR = 6,
  parameter int STEP_INTERVAL    = 2000000,
  parameter int NUM_CHANNELS     = 3,
  parameter int CHANNEL_OFFSET   = 2
) (
  input logic        clk,
  input logic        rst,
  hue_fader_if.slave bus
);
  localparam int W        = $clog2(PWM_INTERVAL + 1);
  localparam int STEP_VAL = PWM_INTERVAL / STEPS_PER_SECTOR;
  localparam int SW       = (STEPS_PER_SECTOR > 1) ? $clog2(STEPS_PER_SECTOR) : 1;

  mode_e                     r_mode_q;
  logic [2:0]                r_sector;
  logic [SW-1:0]             r_step;
  logic                      r_step_tick;
  logic                      r_wrap;
  logic [NUM_CHANNELS*W-1:0] r_pwm_value;

  logic                      w_clr;
  logic                      w_tick;
  logic                      w_step_last;
  logic                      w_sector_last;
  logic [SW-1:0]             w_next_step;
  logic [2:0]                w_next_sector;
  logic [W-1:0]              w_ramp;
  logic [NUM_CHANNELS*W-1:0] w_pwm_next;

  assign w_clr = (mode_e'(bus.mode) != r_mode_q);

  fade_tick_gen #(
    .STEP_INTERVAL(STEP_INTERVAL)
  ) u_tick_gen (
    .clk   (clk),
    .rst   (rst),
    .i_en  (bus.en),
    .i_clr (w_clr),
    .o_tick(w_tick)
  );

  // BREATHE only uses sectors 0 (rise) and 1 (fall).
  assign w_step_last   = (r_step == SW'(STEPS_PER_SECTOR - 1));
  assign w_sector_last = (r_sector == ((r_mode_q == MODE_BREATHE) ? 3'd1 : 3'(NUM_SECTORS - 1)));
  assign w_next_step   = w_step_last ? '0 : r_step + 1'b1;
  assign w_next_sector = !w_step_last  ? r_sector :
                         w_sector_last ? 3'd0     : r_sector + 3'd1;

  // step < STEPS_PER_SECTOR keeps the ramp within full scale.
  assign w_ramp = W'(int'(r_step) * STEP_VAL);

  always_comb begin
    w_pwm_next = '0;
    for (int k = 0; k < NUM_CHANNELS; k++) begin
      case (shape_of(r_mode_q, r_sector, k, CHANNEL_OFFSET))
        SH_RISE: w_pwm_next[k*W +: W] = w_ramp;
        SH_HIGH: w_pwm_next[k*W +: W] = W'(PWM_INTERVAL);
        SH_FALL: w_pwm_next[k*W +: W] = W'(PWM_INTERVAL) - w_ramp;
        default: w_pwm_next[k*W +: W] = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode_q    <= MODE_HUE;
      r_sector    <= '0;
      r_step      <= '0;
      r_step_tick <= 1'b0;
      r_wrap      <= 1'b0;
      r_pwm_value <= '0;
    end else begin
      r_mode_q    <= mode_e'(bus.mode);
      r_pwm_value <= w_pwm_next;
      r_step_tick <= 1'b0;
      r_wrap      <= 1'b0;
      if (w_clr) begin
        r_sector <= '0;
        r_step   <= '0;
      end else if (w_tick) begin
        r_sector    <= w_next_sector;
        r_step      <= w_next_step;
        r_step_tick <= 1'b1;
        r_wrap      <= (w_next_step == '0) && (w_next_sector == 3'd0);
      end
    end
  end

  assign bus.pwm_value = r_pwm_value;
  assign bus.sector    = r_sector;
  assign bus.step_tick = r_step_tick;
  assign bus.wrap      = r_wrap;
endmodule

// File: tb/tb_hue_fader.sv
// Bench for hue_fader: directed scenarios with a tick-driven scoreboard of hand-computed levels.
module tb_hue_fader;
  localparam int W   = 4;
  localparam int NCH = 3;
  localparam int ENT = 3 + 1 + NCH * W;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hue_fader_if #(.NUM_CHANNELS(NCH), .W(W)) bus ();

  hue_fader #(
    .PWM_INTERVAL    (12),
    .STEPS_PER_SECTOR(3),
    .STEP_INTERVAL   (4),
    .NUM_CHANNELS    (NCH),
    .CHANNEL_OFFSET  (2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  logic [ENT-1:0] exp_q[$];

  // ch0 level by position index (sector*3+step) over one full HUE wheel.
  int hue_c0[18] = '{0, 4, 8, 12, 12, 12, 12, 12, 12, 12, 8, 4, 0, 0, 0, 0, 0, 0};
  int brt[6]     = '{0, 4, 8, 12, 8, 4};

  // Entry layout: {sector, wrap, ch2, ch1, ch0}. ch1 lags ch0 by 6 positions, ch2 by 12.
  function automatic logic [ENT-1:0] hue_ent(input int p);
    int q;
    logic [NCH*W-1:0] pw;
    q  = p % 18;
    pw = {W'(hue_c0[(q + 6) % 18]), W'(hue_c0[(q + 12) % 18]), W'(hue_c0[q])};
    return {3'(q / 3), (q == 0), pw};
  endfunction

  function automatic logic [ENT-1:0] brt_ent(input int p);
    int q;
    logic [W-1:0] v;
    q = p % 6;
    v = W'(brt[q]);
    return {3'(q / 3), (q == 0), v, v, v};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_tick(input int max, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.step_tick !== 1'b1 && n < max);
    if (bus.step_tick !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL tick_timeout: no step_tick within %0d cycles at %0t", max, $time);
    end
  endtask

  // Monitor: on each step_tick capture sector/wrap, then pwm one cycle later.
  initial begin
    logic [2:0]     s;
    logic           wr;
    logic [ENT-1:0] e;
    logic [ENT-1:0] act;
    forever begin
      @(negedge clk);
      if (bus.step_tick === 1'b1) begin
        s  = bus.sector;
        wr = bus.wrap;
        @(negedge clk);
        act = {s, wr, bus.pwm_value};
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_tick: got sector=%0d wrap=%0d pwm=0x%0h with empty queue", s, wr, bus.pwm_value);
        end else begin
          e = exp_q.pop_front();
          if (act !== e) begin
            errors++;
            $display("FAIL tick_entry: got sector=%0d wrap=%0b pwm=0x%03h expected sector=%0d wrap=%0b pwm=0x%03h at %0t",
                     act[ENT-1 -: 3], act[NCH*W], act[NCH*W-1:0], e[ENT-1 -: 3], e[NCH*W], e[NCH*W-1:0], $time);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int n;
    logic saw_tick;
    logic [ENT-1:0] ent;

    // Reset
    rst = 1'b1;
    bus.en = 1'b0;
    bus.mode = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_pwm", 32'(bus.pwm_value), 32'h0);
    check("reset_sector", 32'(bus.sector), 32'd0);
    check("reset_step_tick", 32'(bus.step_tick), 32'd0);
    check("reset_wrap", 32'(bus.wrap), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("release_pwm", 32'(bus.pwm_value), 32'hC00);
    check("release_sector", 32'(bus.sector), 32'd0);

    // HUE sweep across more than one full wheel
    for (int p = 1; p <= 20; p++) exp_q.push_back(hue_ent(p));
    bus.en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      wait_tick(8, n);
      check("hue_period", 32'(n), 32'd4);
    end
    bus.en = 1'b0;
    @(negedge clk);
    ent = hue_ent(20);
    check("pre_pause_sector", 32'(bus.sector), 32'(ent[ENT-1 -: 3]));
    check("pre_pause_pwm", 32'(bus.pwm_value), 32'(ent[NCH*W-1:0]));

    // Pause two counts into a tick
    exp_q.push_back(hue_ent(21));
    bus.en = 1'b1;
    repeat (2) @(negedge clk);
    bus.en = 1'b0;
    saw_tick = 1'b0;
    repeat (10) begin
      @(negedge clk);
      saw_tick = saw_tick | bus.step_tick;
    end
    check("pause_no_tick", 32'(saw_tick), 32'd0);
    check("pause_sector", 32'(bus.sector), 32'(ent[ENT-1 -: 3]));
    check("pause_pwm", 32'(bus.pwm_value), 32'(ent[NCH*W-1:0]));
    bus.en = 1'b1;
    wait_tick(8, n);
    check("pause_resume", 32'(n), 32'd2);

    // Advance to HUE sector 3 step 1, then switch to BREATHE
    for (int p = 22; p <= 28; p++) exp_q.push_back(hue_ent(p));
    for (int i = 0; i < 7; i++) begin
      wait_tick(8, n);
      check("hue_period2", 32'(n), 32'd4);
    end
    for (int p = 1; p <= 7; p++) exp_q.push_back(brt_ent(p));
    bus.mode = 1'b1;
    @(negedge clk);
    check("clr_no_tick", 32'(bus.step_tick), 32'd0);
    check("clr_sector", 32'(bus.sector), 32'd0);
    @(negedge clk);
    check("clr_pwm", 32'(bus.pwm_value), 32'h000);
    wait_tick(8, n);
    check("clr_first_tick", 32'(n), 32'd3);
    for (int i = 0; i < 6; i++) begin
      wait_tick(8, n);
      check("breathe_period", 32'(n), 32'd4);
    end

    // Back to HUE, run to sector 4, then reset mid-run
    bus.en = 1'b0;
    bus.mode = 1'b0;
    @(negedge clk);
    for (int p = 1; p <= 12; p++) exp_q.push_back(hue_ent(p));
    bus.en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      wait_tick(8, n);
      check("hue_period3", 32'(n), 32'd4);
    end
    bus.en = 1'b0;
    @(negedge clk);
    check("mid_sector", 32'(bus.sector), 32'd4);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_pwm", 32'(bus.pwm_value), 32'h0);
    check("midrst_sector", 32'(bus.sector), 32'd0);
    check("midrst_step_tick", 32'(bus.step_tick), 32'd0);
    check("midrst_wrap", 32'(bus.wrap), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_release_pwm", 32'(bus.pwm_value), 32'hC00);
    for (int p = 1; p <= 3; p++) exp_q.push_back(hue_ent(p));
    bus.en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_tick(8, n);
      check("restart_period", 32'(n), 32'd4);
    end
    bus.en = 1'b0;
    repeat (3) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
